// File: rtl/blink_pkg.sv
// Shared types and constants for the blinker and its delay decoder.
package blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_PAUSED
  } state_t;

  localparam int DELAY_W           = 4;
  localparam int STEP_W            = 6;
  localparam int TICK_DIV_DEF      = 50000;
  localparam int STEP_TICKS_DEF    = 100;
  localparam int TIMEOUT_STEPS_DEF = 40;

  // The blinker encodes delay as (code + 1) steps; codes above the 4-bit range clamp.
  function automatic logic [DELAY_W-1:0] steps_to_code(input logic [STEP_W-1:0] steps);
    if (steps > STEP_W'(16)) begin
      return '1;
    end
    return DELAY_W'(steps - STEP_W'(1));
  endfunction

endpackage

// File: rtl/blink_step_timer.sv
// Cycle counter wrapping every STEP_CYCLES clocks, feeding a saturating step counter.
module blink_step_timer
  import blink_pkg::*;
#(
  parameter int STEP_CYCLES = TICK_DIV_DEF * STEP_TICKS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  output logic [STEP_W-1:0] o_steps
);

  localparam int CYC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [CYC_W-1:0]  r_cyc;
  logic [STEP_W-1:0] r_steps;
  logic              w_wrap;
  logic [STEP_W-1:0] w_steps_next;

  // o_steps includes this cycle's increment so a clearing cycle still gets counted.
  assign w_wrap       = (r_cyc == CYC_W'(STEP_CYCLES - 1));
  assign w_steps_next = (w_wrap && (r_steps != '1)) ? r_steps + STEP_W'(1) : r_steps;
  assign o_steps      = w_steps_next;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cyc   <= '0;
      r_steps <= '0;
    end else begin
      r_cyc   <= w_wrap ? '0 : r_cyc + CYC_W'(1);
      r_steps <= w_steps_next;
    end
  end

endmodule

// File: rtl/blink_decoder.sv
// Recovers the blinker's delay setting by timing the interval between LED pattern changes.
module blink_decoder
  import blink_pkg::*;
#(
  parameter int TICK_DIV      = TICK_DIV_DEF,
  parameter int STEP_TICKS    = STEP_TICKS_DEF,
  parameter int TIMEOUT_STEPS = TIMEOUT_STEPS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         led_in,
  output logic [DELAY_W-1:0] delay_code,
  output logic               valid,
  output logic               paused,
  output logic               short_err
);

  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         r_prev;
  logic               r_chg;
  state_t             r_state;
  logic [DELAY_W-1:0] r_delay_code;
  logic               r_valid;
  logic               r_paused;
  logic               r_short_err;
  logic [STEP_W-1:0]  w_steps;
  logic               w_timeout;

  // Synchronize the asynchronous LEDs, then register any pattern change as a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_chg   <= 1'b0;
    end else begin
      r_sync1 <= led_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_chg   <= (r_sync2 != r_prev);
    end
  end

  blink_step_timer #(
    .STEP_CYCLES(TICK_DIV * STEP_TICKS)
  ) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .i_clear(r_chg),
    .o_steps(w_steps)
  );

  assign w_timeout = (w_steps >= STEP_W'(TIMEOUT_STEPS));

  // A change always wins over a coincident timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_delay_code <= '0;
      r_valid      <= 1'b0;
      r_paused     <= 1'b0;
      r_short_err  <= 1'b0;
    end else begin
      r_short_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_chg) r_state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (r_chg) begin
            if (w_steps != '0) begin
              r_delay_code <= steps_to_code(w_steps);
              r_valid      <= 1'b1;
            end else begin
              r_short_err  <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state  <= ST_PAUSED;
            r_paused <= 1'b1;
            r_valid  <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (r_chg) begin
            r_state  <= ST_MEASURE;
            r_paused <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign delay_code = r_delay_code;
  assign valid      = r_valid;
  assign paused     = r_paused;
  assign short_err  = r_short_err;

endmodule

// File: tb/tb_blink_decoder.sv
// Directed self-checking bench for blink_decoder with S = 10 cycles per step.
module tb_blink_decoder;

  logic       clk;
  logic       reset;
  logic [3:0] led_in;
  logic [3:0] delay_code;
  logic       valid;
  logic       paused;
  logic       short_err;
  logic [3:0] led_in2;
  logic [3:0] delay_code2;
  logic       valid2;
  logic       paused2;
  logic       short_err2;

  int errors = 0;
  int checks = 0;

  blink_decoder #(.TICK_DIV(2), .STEP_TICKS(5), .TIMEOUT_STEPS(8)) u_dut (
    .clk(clk), .reset(reset), .led_in(led_in),
    .delay_code(delay_code), .valid(valid), .paused(paused), .short_err(short_err)
  );

  // Long timeout instance so periods above 8 steps can be decoded without pausing.
  blink_decoder #(.TICK_DIV(2), .STEP_TICKS(5), .TIMEOUT_STEPS(40)) u_dut_long (
    .clk(clk), .reset(reset), .led_in(led_in2),
    .delay_code(delay_code2), .valid(valid2), .paused(paused2), .short_err(short_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle_led;
    led_in[0] = ~led_in[0];
  endtask

  task automatic toggle_led2;
    led_in2[0] = ~led_in2[0];
  endtask

  task automatic test_reset;
    reset = 1'b1;
    led_in = 4'h0;
    led_in2 = 4'h0;
    wait_cycles(3);
    checks++; if (delay_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_code got=%0d exp=0", delay_code); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL reset_paused got=%0b exp=0", paused); end
    checks++; if (short_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_short got=%0b exp=0", short_err); end
    reset = 1'b0;
    wait_cycles(5);
  endtask

  // 30-cycle period gives 3 steps, code 2; the first edge only opens the measurement.
  task automatic test_first_period;
    toggle_led();
    wait_cycles(5);
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL first_edge_valid got=%0b exp=0", valid); end
    wait_cycles(25);
    toggle_led();
    wait_cycles(3);
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early_valid got=%0b exp=0", valid); end
    wait_cycles(1);
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL period30_valid got=%0b exp=1", valid); end
    checks++; if (delay_code !== 4'd2) begin errors++; $display("[TB] FAIL period30_code got=%0d exp=2", delay_code); end
  endtask

  task automatic test_short;
    wait_cycles(5);
    toggle_led();
    wait_cycles(3);
    checks++; if (short_err !== 1'b0) begin errors++; $display("[TB] FAIL short_early got=%0b exp=0", short_err); end
    wait_cycles(1);
    checks++; if (short_err !== 1'b1) begin errors++; $display("[TB] FAIL short_pulse got=%0b exp=1", short_err); end
    checks++; if (delay_code !== 4'd2) begin errors++; $display("[TB] FAIL short_code got=%0d exp=2", delay_code); end
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL short_valid got=%0b exp=1", valid); end
    wait_cycles(1);
    checks++; if (short_err !== 1'b0) begin errors++; $display("[TB] FAIL short_width got=%0b exp=0", short_err); end
  endtask

  // 19 cycles is exactly one step; 80 cycles hits the timeout on the change cycle.
  task automatic test_boundaries;
    wait_cycles(14);
    toggle_led();
    wait_cycles(4);
    checks++; if (delay_code !== 4'd0) begin errors++; $display("[TB] FAIL one_step_code got=%0d exp=0", delay_code); end
    wait_cycles(76);
    toggle_led();
    wait_cycles(4);
    checks++; if (delay_code !== 4'd7) begin errors++; $display("[TB] FAIL timeout_tie_code got=%0d exp=7", delay_code); end
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL timeout_tie_paused got=%0b exp=0", paused); end
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL timeout_tie_valid got=%0b exp=1", valid); end
    wait_cycles(75);
    toggle_led();
    wait_cycles(4);
    checks++; if (delay_code !== 4'd6) begin errors++; $display("[TB] FAIL period79_code got=%0d exp=6", delay_code); end
  endtask

  task automatic test_pause;
    wait_cycles(79);
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL pause_early got=%0b exp=0", paused); end
    wait_cycles(1);
    checks++; if (paused !== 1'b1) begin errors++; $display("[TB] FAIL pause_set got=%0b exp=1", paused); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL pause_valid got=%0b exp=0", valid); end
    checks++; if (delay_code !== 4'd6) begin errors++; $display("[TB] FAIL pause_code got=%0d exp=6", delay_code); end
    toggle_led();
    wait_cycles(4);
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL resume_paused got=%0b exp=0", paused); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL resume_valid got=%0b exp=0", valid); end
    wait_cycles(26);
    toggle_led();
    wait_cycles(4);
    checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL after_resume_valid got=%0b exp=1", valid); end
    checks++; if (delay_code !== 4'd2) begin errors++; $display("[TB] FAIL after_resume_code got=%0d exp=2", delay_code); end
  endtask

  task automatic test_reset_mid;
    wait_cycles(11);
    reset = 1'b1;
    led_in = 4'h0;
    wait_cycles(1);
    checks++; if (delay_code !== 4'd0) begin errors++; $display("[TB] FAIL midreset_code got=%0d exp=0", delay_code); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got=%0b exp=0", valid); end
    checks++; if (paused !== 1'b0) begin errors++; $display("[TB] FAIL midreset_paused got=%0b exp=0", paused); end
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(10);
    toggle_led();
    wait_cycles(4);
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_first_valid got=%0b exp=0", valid); end
    checks++; if (delay_code !== 4'd0) begin errors++; $display("[TB] FAIL post_reset_first_code got=%0d exp=0", delay_code); end
    wait_cycles(26);
    toggle_led();
    wait_cycles(4);
    checks++; if (delay_code !== 4'd2) begin errors++; $display("[TB] FAIL post_reset_code got=%0d exp=2", delay_code); end
  endtask

  // 200 cycles = 20 steps clamps to 15; 150 cycles = 15 steps decodes to 14.
  task automatic test_clamp;
    toggle_led2();
    wait_cycles(200);
    toggle_led2();
    wait_cycles(4);
    checks++; if (delay_code2 !== 4'd15) begin errors++; $display("[TB] FAIL clamp_code got=%0d exp=15", delay_code2); end
    checks++; if (valid2 !== 1'b1) begin errors++; $display("[TB] FAIL clamp_valid got=%0b exp=1", valid2); end
    checks++; if (paused2 !== 1'b0) begin errors++; $display("[TB] FAIL clamp_paused got=%0b exp=0", paused2); end
    wait_cycles(146);
    toggle_led2();
    wait_cycles(4);
    checks++; if (delay_code2 !== 4'd14) begin errors++; $display("[TB] FAIL period150_code got=%0d exp=14", delay_code2); end
  endtask

  initial begin
    reset = 1'b1;
    led_in = 4'h0;
    led_in2 = 4'h0;
    test_reset();
    test_first_period();
    test_short();
    test_boundaries();
    test_pause();
    test_reset_mid();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blink_decoder.md
BLINK_DECODER -- requirements
Module: blink_decoder

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per tick (1 ms at 50 MHz).
REQ-002 Parameter STEP_TICKS, default 100, ticks per delay step; S = TICK_DIV*STEP_TICKS cycles.
REQ-003 Parameter TIMEOUT_STEPS, default 40, steps without a change before PAUSED.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 led_in  input  4  observed LED pattern, asynchronous to clk.
REQ-007 delay_code  output  4  decoded blinker delay setting.
REQ-008 valid  output  1  high while delay_code reflects a completed period measurement.
REQ-009 paused  output  1  high while led_in has been static for the timeout.
REQ-010 short_err  output  1  one-cycle pulse: period shorter than one step.

Function
REQ-011 led_in SHALL pass a 2-FF synchronizer; a change SHALL be detected when the synchronized value differs from the registered previous value (any bit), producing a 1-cycle chg.
REQ-012 On every chg cycle the cycle counter and step counter SHALL clear to 0. The cycle counter counts to S-1 and wraps; each wrap increments the step counter.
REQ-013 Step counter SHALL be 6 bits, saturating at 63.
REQ-014 The chg cycle's own increment SHALL count before the clear, so C cycles between two chg events yield steps = floor(C/S) (saturated).
REQ-015 FSM states: IDLE, MEASURE, PAUSED.
REQ-016 IDLE: on chg -> MEASURE; no output update (first edge only opens a measurement).
REQ-017 MEASURE, chg with steps >= 1: delay_code <= min(steps-1, 15), valid <= 1, stay MEASURE.
REQ-018 MEASURE, chg with steps == 0: short_err pulses 1 cycle; delay_code and valid unchanged; counters restart.
REQ-019 MEASURE, steps reaching TIMEOUT_STEPS with no chg -> PAUSED; paused <= 1, valid <= 0, delay_code held.
REQ-020 PAUSED: on chg -> MEASURE, paused <= 0; no output update on that edge.
REQ-021 chg coinciding with timeout SHALL take the chg path (REQ-017/018); no transition to PAUSED.
REQ-022 Latency: delay_code/valid/short_err update on the clock edge after the chg cycle; led_in change to output update is 4 cycles.

Reset
REQ-023 While reset is high at a clk edge: state IDLE, counters 0, synchronizer and previous-value registers 0, delay_code 0, valid 0, paused 0, short_err 0.
REQ-024 Reset mid-measurement SHALL discard the partial period; the first chg after reset follows REQ-016.

Structure
REQ-025 Package blink_pkg SHALL hold the state typedef, DELAY_W=4, STEP_W=6 and default parameter constants, shared with the existing blinker.
REQ-026 One sub-module, blink_step_timer (cycle counter plus saturating step counter, clear input, steps output), SHALL be instantiated; FSM, synchronizer and decode live in blink_decoder.
REQ-027 No divider SHALL be inferred; decode uses the step counter only.

Verification (bench parameters TICK_DIV=2, STEP_TICKS=5, TIMEOUT_STEPS=8, so S=10)
REQ-028 Toggle led_in[0] every 30 cycles -> after the second toggle delay_code=2, valid=1, 4 cycles after the edge.
REQ-029 Toggles 30 cycles apart, then one 9 cycles later -> short_err single pulse; delay_code stays 2, valid stays 1.
REQ-030 Toggles 200 cycles apart -> delay_code=15 (clamped from steps 20), valid=1.
REQ-031 After a valid measurement, hold led_in static -> paused=1, valid=0 once 80 cycles pass after the last chg; next toggle clears paused with no code update; the following toggle updates.
REQ-032 Assert reset 15 cycles into a measurement -> all outputs 0 next edge; first toggle after release produces no update.
